// File: rtl/mode_counter.sv
// Configurable counter: up, down, ping-pong or hold over 0..limit, with wrap or
// saturate at the boundary, synchronous load, a terminal-count flag and Gray output.
module mode_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             wrap,
    input  logic [WIDTH-1:0] limit,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] sa,
    output logic             dir,
    output logic             tc,
    output logic [WIDTH-1:0] gray
);

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_PING = 2'b10,
        MODE_HOLD = 2'b11
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic [WIDTH-1:0] sa_q, sa_d;
    dir_t             dir_q, dir_d;
    logic             tc_q, tc_d;
    mode_t            mode_sel;

    assign mode_sel = mode_t'(mode);

    always_comb begin
        sa_d  = sa_q;
        dir_d = dir_q;
        tc_d  = 1'b0;
        if (load) begin
            sa_d = (load_val > limit) ? limit : load_val;
        end else if (en && mode_sel != MODE_HOLD) begin
            // A limit lowered below the current count pulls the count back first.
            if (sa_q > limit) begin
                sa_d = limit;
            end else begin
                case (mode_sel)
                    MODE_UP: begin
                        if (sa_q == limit) begin
                            tc_d = 1'b1;
                            if (wrap) sa_d = ZERO;
                        end else begin
                            sa_d = sa_q + ONE;
                        end
                    end
                    MODE_DOWN: begin
                        if (sa_q == ZERO) begin
                            tc_d = 1'b1;
                            if (wrap) sa_d = limit;
                        end else begin
                            sa_d = sa_q - ONE;
                        end
                    end
                    MODE_PING: begin
                        if (limit == ZERO) begin
                            tc_d = 1'b1;
                        end else if (dir_q == DIR_UP) begin
                            if (sa_q == limit) begin
                                sa_d  = limit - ONE;
                                dir_d = DIR_DOWN;
                                tc_d  = 1'b1;
                            end else begin
                                sa_d = sa_q + ONE;
                            end
                        end else begin
                            if (sa_q == ZERO) begin
                                sa_d  = ONE;
                                dir_d = DIR_UP;
                                tc_d  = 1'b1;
                            end else begin
                                sa_d = sa_q - ONE;
                            end
                        end
                    end
                    default: begin
                        sa_d = sa_q;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sa_q  <= ZERO;
            dir_q <= DIR_UP;
            tc_q  <= 1'b0;
        end else begin
            sa_q  <= sa_d;
            dir_q <= dir_d;
            tc_q  <= tc_d;
        end
    end

    assign sa   = sa_q;
    assign dir  = dir_q;
    assign tc   = tc_q;
    assign gray = sa_q ^ (sa_q >> 1);

endmodule

// File: tb/tb_mode_counter.sv
// Directed bench for mode_counter (WIDTH=4): each vector drives inputs on the
// falling edge, lets one rising edge pass, then compares against hand-computed values.
module tb_mode_counter;

    localparam int WIDTH = 4;

    logic             clock;
    logic             reset;
    logic             en;
    logic [1:0]       mode;
    logic             wrap;
    logic [WIDTH-1:0] limit;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] sa;
    logic             dir;
    logic             tc;
    logic [WIDTH-1:0] gray;

    int check_count = 0;
    int error_count = 0;
    int edge_count  = 0;

    mode_counter #(.WIDTH(WIDTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .wrap     (wrap),
        .limit    (limit),
        .load     (load),
        .load_val (load_val),
        .sa       (sa),
        .dir      (dir),
        .tc       (tc),
        .gray     (gray)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One rising edge, then settle on the falling edge before sampling.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        edge_count++;
        $display("edge %0d: rst=%0d ld=%0d en=%0d mode=%0d wrap=%0d lim=%0d -> sa=%0d dir=%0d tc=%0d gray=%0d",
                 edge_count, reset, load, en, mode, wrap, limit, sa, dir, tc, gray);
    endtask

    task automatic check_state(input string tag, input int exp_sa, input int exp_dir,
                               input int exp_tc);
        check_val({tag, ".sa"},  32'(sa),  32'(exp_sa));
        check_val({tag, ".dir"}, 32'(dir), 32'(exp_dir));
        check_val({tag, ".tc"},  32'(tc),  32'(exp_tc));
    endtask

    int pp_sa  [8] = '{1, 2, 3, 2, 1, 0, 1, 2};
    int pp_dir [8] = '{0, 0, 0, 1, 1, 1, 0, 0};
    int pp_tc  [8] = '{0, 0, 0, 1, 0, 0, 1, 0};
    int dn_sa  [5] = '{2, 1, 0, 0, 0};
    int dn_tc  [5] = '{0, 0, 0, 1, 1};

    initial begin
        reset = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd5;
        mode = 2'b00; wrap = 1'b1; limit = 4'd9;
        @(negedge clock);

        // Reset wins over load and enable
        tick(); tick();
        check_state("reset", 0, 0, 0);
        check_val("reset.gray", 32'(gray), 32'd0);

        // Up, wrap at 9
        reset = 1'b0; load = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check_state($sformatf("up_wrap[%0d]", i), i % 10, 0, (i == 10) ? 1 : 0);
        end

        // Down, saturate at 0
        mode = 2'b01; wrap = 1'b0; limit = 4'd15; load = 1'b1; load_val = 4'd3;
        tick();
        check_state("down_load", 3, 0, 0);
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_state($sformatf("down_sat[%0d]", i), dn_sa[i], 0, dn_tc[i]);
        end

        // Ping-pong over 0..3 from reset
        reset = 1'b1;
        tick();
        reset = 1'b0; mode = 2'b10; limit = 4'd3;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_state($sformatf("ping[%0d]", i), pp_sa[i], pp_dir[i], pp_tc[i]);
        end

        // Load beats enable and is clamped to limit
        limit = 4'd9; load = 1'b1; load_val = 4'd12;
        tick();
        check_state("load_clamp", 9, 0, 0);
        load = 1'b0;
        tick();
        check_state("ping_turn", 8, 1, 1);
        tick();
        check_state("ping_down", 7, 1, 0);
        reset = 1'b1;
        tick();
        check_state("reset_in_ping", 0, 0, 0);
        reset = 1'b0;

        // Limit lowered below the count
        mode = 2'b00; limit = 4'd15; load = 1'b1; load_val = 4'd8;
        tick();
        check_state("load8", 8, 0, 0);
        load = 1'b0; limit = 4'd5;
        tick();
        check_state("limit_drop", 5, 0, 0);
        en = 1'b0;
        tick();
        check_state("en_off", 5, 0, 0);
        check_val("en_off.gray", 32'(gray), 32'h7);

        // Up saturate: tc stays high while held at the limit
        en = 1'b1; wrap = 1'b0;
        tick();
        check_state("up_sat0", 5, 0, 1);
        tick();
        check_state("up_sat1", 5, 0, 1);
        mode = 2'b11;
        tick();
        check_state("hold", 5, 0, 0);

        // Down wrap from 0 goes to limit
        mode = 2'b01; wrap = 1'b1; load = 1'b1; load_val = 4'd0;
        tick();
        load = 1'b0;
        tick();
        check_state("down_wrap", 5, 0, 1);

        // Full-range natural wrap
        mode = 2'b00; limit = 4'd15; load = 1'b1; load_val = 4'd15;
        tick();
        check_val("full.gray", 32'(gray), 32'h8);
        load = 1'b0;
        tick();
        check_state("full_wrap", 0, 0, 1);

        // Ping-pong with limit 0 flags every enabled edge
        mode = 2'b10; limit = 4'd0;
        tick();
        check_state("ping_lim0_a", 0, 0, 1);
        tick();
        check_state("ping_lim0_b", 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

    // Overall time bound so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000 ns");
        $fatal(1, "timeout");
    end

endmodule
